// File: rtl/ams_pkg.sv
// rtl/ams_pkg.sv - shared constants, config word type and field helpers for the AMS PWM-DAC
package ams_pkg;

   localparam int AMS_PWM_PERIOD = 156;
   localparam int AMS_PWM_SUBS   = 16;

   localparam int AMS_CFG_BASE_MSB   = 23;
   localparam int AMS_CFG_BASE_LSB   = 16;
   localparam int AMS_CFG_DITHER_MSB = 15;
   localparam int AMS_CFG_DITHER_LSB = 0;

   typedef logic [23:0] ams_pwm_cfg_t;

   function automatic logic [7:0] ams_cfg_base(input ams_pwm_cfg_t cfg);
      return cfg[AMS_CFG_BASE_MSB:AMS_CFG_BASE_LSB];
   endfunction

   function automatic logic [15:0] ams_cfg_dither(input ams_pwm_cfg_t cfg);
      return cfg[AMS_CFG_DITHER_MSB:AMS_CFG_DITHER_LSB];
   endfunction

endpackage

// File: rtl/ams_pwm_timebase.sv
// rtl/ams_pwm_timebase.sv - PWM period counter, super-cycle sub-period counter and boundary flag
// Reset parks both counters at their last value so the first edge after release is a boundary.
module ams_pwm_timebase
   import ams_pkg::*;
#(
   parameter int PERIOD = AMS_PWM_PERIOD,
   parameter int SUBS   = AMS_PWM_SUBS,
   parameter int CW     = (PERIOD > 2) ? $clog2(PERIOD) : 1,
   parameter int SW     = $clog2(SUBS)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   output logic [CW-1:0] cnt_o,
   output logic [SW-1:0] sub_o,
   output logic          bnd_o
);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [SW-1:0] sub_q, sub_d;
   logic          cnt_wrap;
   logic          sub_wrap;

   always_comb begin
      cnt_wrap = (cnt_q == CW'(PERIOD - 1));
      sub_wrap = (sub_q == SW'(SUBS - 1));
      cnt_d    = cnt_wrap ? '0 : cnt_q + 1'b1;
      sub_d    = sub_q;
      if (cnt_wrap) begin
         sub_d = sub_wrap ? '0 : sub_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= CW'(PERIOD - 1);
         sub_q <= SW'(SUBS - 1);
      end else begin
         cnt_q <= cnt_d;
         sub_q <= sub_d;
      end
   end

   assign cnt_o = cnt_q;
   assign sub_o = sub_q;
   assign bnd_o = cnt_wrap && sub_wrap;

endmodule

// File: rtl/ams_pwm_dac.sv
// rtl/ams_pwm_dac.sv - one PWM-DAC channel: input register, boundary-loaded shadow, dithered compare
// Define AMS_PWM_DITHER_EN to add dither[sub] to the base duty; otherwise thr = base.
module ams_pwm_dac
   import ams_pkg::*;
#(
   parameter int PERIOD = AMS_PWM_PERIOD
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  ams_pwm_cfg_t cfg_i,
   output logic         pwm_o,
   output logic         load_o,
   output logic         sat_o
);

   localparam int CW = (PERIOD > 2) ? $clog2(PERIOD) : 1;
   localparam int SW = $clog2(AMS_PWM_SUBS);

   logic [CW-1:0] cnt;
   logic [SW-1:0] sub;
   logic          bnd;

   ams_pwm_timebase #(
      .PERIOD (PERIOD),
      .SUBS   (AMS_PWM_SUBS),
      .CW     (CW),
      .SW     (SW)
   ) u_timebase (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .cnt_o  (cnt),
      .sub_o  (sub),
      .bnd_o  (bnd)
   );

   ams_pwm_cfg_t cfg_q, cfg_d;
   ams_pwm_cfg_t shadow_q, shadow_d;
   logic         load_q, load_d;
   logic         sat_q, sat_d;
   logic         pwm_q, pwm_d;
   logic [8:0]   thr;

`ifdef AMS_PWM_DITHER_EN
   logic [15:0] dither;
   assign dither = ams_cfg_dither(shadow_q);
   assign thr    = {1'b0, ams_cfg_base(shadow_q)} + {8'd0, dither[sub]};
`else
   logic unused_dither;
   assign unused_dither = ^{ams_cfg_dither(shadow_q), sub};
   assign thr           = {1'b0, ams_cfg_base(shadow_q)};
`endif

   // Shadow and saturation flag only move on the super-cycle boundary so a period is never split.
   always_comb begin
      cfg_d    = cfg_i;
      shadow_d = shadow_q;
      load_d   = 1'b0;
      sat_d    = sat_q;
      if (bnd) begin
         shadow_d = cfg_q;
         load_d   = 1'b1;
         sat_d    = ({1'b0, ams_cfg_base(cfg_q)} >= 9'(PERIOD));
      end
      pwm_d = (9'(cnt) < thr);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cfg_q    <= '0;
         shadow_q <= '0;
         load_q   <= 1'b0;
         sat_q    <= 1'b0;
         pwm_q    <= 1'b0;
      end else begin
         cfg_q    <= cfg_d;
         shadow_q <= shadow_d;
         load_q   <= load_d;
         sat_q    <= sat_d;
         pwm_q    <= pwm_d;
      end
   end

   assign pwm_o  = pwm_q;
   assign load_o = load_q;
   assign sat_o  = sat_q;

endmodule

// File: tb/tb_ams_pwm_dac.sv
// tb/tb_ams_pwm_dac.sv - directed self-checking bench for ams_pwm_dac
module tb_ams_pwm_dac;

   localparam int PER   = 156;
   localparam int SUPER = 2496;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic [23:0] cfg_i = 24'h0;
   logic        pwm_o;
   logic        load_o;
   logic        sat_o;

   int n_vec = 0;
   int n_err = 0;
   int hi[16];
   int loads;

   ams_pwm_dac dut (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .cfg_i  (cfg_i),
      .pwm_o  (pwm_o),
      .load_o (load_o),
      .sat_o  (sat_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic wait_load(output int cycles, output bit seen);
      seen   = 1'b0;
      cycles = 0;
      while (!seen && cycles < 3000) begin
         tick();
         cycles++;
         if (load_o) seen = 1'b1;
      end
   endtask

   // Starts right after a boundary edge; hi[p] gets the high count of period p.
   task automatic measure(input int nper);
      loads = 0;
      for (int p = 0; p < nper; p++) begin
         hi[p] = 0;
         for (int c = 0; c < PER; c++) begin
            tick();
            if (pwm_o) hi[p]++;
            if (load_o) loads++;
         end
      end
   endtask

   task automatic test_reset();
      cfg_i = 24'h00_0000;
      rst_i = 1'b1;
      tick();
      n_vec++; if (pwm_o !== 1'b0)  begin n_err++; $display("FAIL reset_pwm got %b exp 0", pwm_o); end
      n_vec++; if (load_o !== 1'b0) begin n_err++; $display("FAIL reset_load got %b exp 0", load_o); end
      n_vec++; if (sat_o !== 1'b0)  begin n_err++; $display("FAIL reset_sat got %b exp 0", sat_o); end
      tick();
      rst_i = 1'b0;
      tick();
      n_vec++; if (load_o !== 1'b1) begin n_err++; $display("FAIL first_load got %b exp 1", load_o); end
      measure(16);
      for (int p = 0; p < 16; p++) begin
         n_vec++; if (hi[p] !== 0) begin n_err++; $display("FAIL zero_duty sub %0d got %0d exp 0", p, hi[p]); end
      end
      n_vec++; if (loads !== 1)     begin n_err++; $display("FAIL zero_loads got %0d exp 1", loads); end
      n_vec++; if (load_o !== 1'b1) begin n_err++; $display("FAIL load_interval got %b exp 1", load_o); end
      n_vec++; if (sat_o !== 1'b0)  begin n_err++; $display("FAIL zero_sat got %b exp 0", sat_o); end
   endtask

   task automatic test_duty(input logic [23:0] cfg, input int exp0, input int exp_rest,
                            input logic exp_sat, input string name);
      int  cyc;
      bit  seen;
      cfg_i = cfg;
      wait_load(cyc, seen);
      n_vec++; if (!seen || cyc !== SUPER) begin n_err++; $display("FAIL %s load_wait got %0d seen %b exp %0d", name, cyc, seen, SUPER); end
      n_vec++; if (sat_o !== exp_sat) begin n_err++; $display("FAIL %s sat got %b exp %b", name, sat_o, exp_sat); end
      measure(16);
      for (int p = 0; p < 16; p++) begin
         n_vec++;
         if (hi[p] !== ((p == 0) ? exp0 : exp_rest)) begin
            n_err++;
            $display("FAIL %s sub %0d highs got %0d exp %0d", name, p, hi[p], (p == 0) ? exp0 : exp_rest);
         end
      end
   endtask

   task automatic test_midchange();
      int  cyc;
      bit  seen;
      cfg_i = 24'h0F_0000;
      wait_load(cyc, seen);
      n_vec++; if (!seen) begin n_err++; $display("FAIL mid_load_wait got %0d exp %0d", cyc, SUPER); end
      measure(5);
      for (int p = 0; p < 5; p++) begin
         n_vec++; if (hi[p] !== 15) begin n_err++; $display("FAIL mid_pre sub %0d got %0d exp 15", p, hi[p]); end
      end
      cfg_i = 24'h75_0000;
      measure(11);
      for (int p = 0; p < 11; p++) begin
         n_vec++; if (hi[p] !== 15) begin n_err++; $display("FAIL mid_hold sub %0d got %0d exp 15", p + 5, hi[p]); end
      end
      n_vec++; if (loads !== 1 || load_o !== 1'b1) begin n_err++; $display("FAIL mid_load got %0d/%b exp 1/1", loads, load_o); end
      measure(16);
      for (int p = 0; p < 16; p++) begin
         n_vec++; if (hi[p] !== 117) begin n_err++; $display("FAIL mid_new sub %0d got %0d exp 117", p, hi[p]); end
      end
   endtask

   task automatic test_reset_mid();
      measure(7);
      for (int c = 0; c < 40; c++) tick();
      n_vec++; if (pwm_o !== 1'b1) begin n_err++; $display("FAIL rmid_pre_pwm got %b exp 1", pwm_o); end
      rst_i = 1'b1;
      tick();
      n_vec++; if (pwm_o !== 1'b0)  begin n_err++; $display("FAIL rmid_pwm got %b exp 0", pwm_o); end
      n_vec++; if (load_o !== 1'b0) begin n_err++; $display("FAIL rmid_load got %b exp 0", load_o); end
      rst_i = 1'b0;
      tick();
      n_vec++; if (load_o !== 1'b1) begin n_err++; $display("FAIL rmid_first_load got %b exp 1", load_o); end
      measure(16);
      for (int p = 0; p < 16; p++) begin
         n_vec++; if (hi[p] !== 0) begin n_err++; $display("FAIL rmid_shadow0 sub %0d got %0d exp 0", p, hi[p]); end
      end
      n_vec++; if (load_o !== 1'b1) begin n_err++; $display("FAIL rmid_second_load got %b exp 1", load_o); end
      measure(16);
      for (int p = 0; p < 16; p++) begin
         n_vec++; if (hi[p] !== 117) begin n_err++; $display("FAIL rmid_reload sub %0d got %0d exp 117", p, hi[p]); end
      end
   endtask

   initial begin
      test_reset();
      test_duty(24'h4E_0000, 78, 78, 1'b0, "base78");
`ifdef AMS_PWM_DITHER_EN
      test_duty(24'h0A_0001, 11, 10, 1'b0, "dither0");
      test_duty(24'h9C_FFFF, 156, 156, 1'b1, "sat156");
      test_duty(24'h9B_FFFF, 156, 156, 1'b0, "thr156");
`else
      test_duty(24'h0A_0001, 10, 10, 1'b0, "dither0");
      test_duty(24'h9C_FFFF, 156, 156, 1'b1, "sat156");
      test_duty(24'h9B_FFFF, 155, 155, 1'b0, "thr155");
`endif
      test_midchange();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
